// File: rtl/fire_expand_engine.sv
// Configurable 1x1/3x3 conv-expand engine: DSP_NO parallel MACs accumulate one output
// pixel per N accepted IFM beats, then quantise, ReLU and saturate into ofm under a start/done FSM.
module fire_expand_engine #(
  parameter int WIDTH      = 16,
  parameter int DSP_NO     = 128,
  parameter int CHIN       = 32,
  parameter int KERNEL_DIM = 3,
  parameter int WOUT       = 32,
  parameter int FRAC       = 14,
  parameter int RELU       = 1,
  localparam int N    = KERNEL_DIM * KERNEL_DIM * CHIN,
  localparam int AW   = (N > 1) ? $clog2(N) : 1,
  localparam int PIX  = WOUT * WOUT,
  localparam int PW   = $clog2(PIX + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              ifm,
  input  logic                          ifm_valid,
  output logic                          ifm_ready,
  output logic [AW-1:0]                 rom_addr,
  input  logic [DSP_NO*WIDTH-1:0]       kernels,
  input  logic [DSP_NO*2*WIDTH-1:0]     bias,
  output logic [DSP_NO*WIDTH-1:0]       ofm,
  output logic                          ofm_valid,
  input  logic                          ram_ready,
  output logic [PW-1:0]                 pixel_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int ACCW = 2 * WIDTH + $clog2(N);
  localparam int SW   = ACCW + 1;
  localparam logic signed [SW-1:0] MAX_S = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_S = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_QUANT = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            rom_addr_q, rom_addr_d;
  logic [PW-1:0]            pixel_idx_q, pixel_idx_d;
  logic signed [ACCW-1:0]   acc_q [DSP_NO];
  logic signed [ACCW-1:0]   acc_d [DSP_NO];
  logic signed [2*WIDTH-1:0] prod_s [DSP_NO];
  logic [DSP_NO*WIDTH-1:0]  ofm_q, ofm_d;
  logic                     accept_s, last_beat_s, handshake_s, last_pix_s;

  // Bias add in product scale, arithmetic shift to output scale, optional ReLU, saturate.
  function automatic logic [WIDTH-1:0] quantise(input logic signed [ACCW-1:0] acc,
                                                input logic signed [2*WIDTH-1:0] b);
    logic signed [SW-1:0] s;
    logic signed [SW-1:0] q;
    s = $signed({{(SW-ACCW){acc[ACCW-1]}}, acc})
      + $signed({{(SW-2*WIDTH){b[2*WIDTH-1]}}, b});
    q = s >>> FRAC;
    if ((RELU != 0) && q[SW-1]) begin
      q = '0;
    end else if (q > MAX_S) begin
      q = MAX_S;
    end else if (q < MIN_S) begin
      q = MIN_S;
    end else begin
      q = q;
    end
    return q[WIDTH-1:0];
  endfunction

  assign accept_s    = ifm_valid && (state_q == S_ACCUM);
  assign last_beat_s = accept_s && (rom_addr_q == AW'(N - 1));
  assign handshake_s = (state_q == S_OUT) && ram_ready;
  assign last_pix_s  = (pixel_idx_q == PW'(PIX - 1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_ACCUM : S_IDLE;
      S_ACCUM: state_d = last_beat_s ? S_QUANT : S_ACCUM;
      S_QUANT: state_d = S_OUT;
      S_OUT: begin
        if (ram_ready) begin
          state_d = last_pix_s ? S_DONE : S_ACCUM;
        end else begin
          state_d = S_OUT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output decode; busy drops in the same cycle that done pulses
  always_comb begin
    ifm_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    ofm_valid = 1'b0;
    case (state_q)
      S_ACCUM: begin
        ifm_ready = 1'b1;
        busy      = 1'b1;
      end
      S_QUANT: busy = 1'b1;
      S_OUT: begin
        busy      = 1'b1;
        ofm_valid = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Per-channel signed products of the current beat and its ROM weight
  always_comb begin
    for (int i = 0; i < DSP_NO; i++) begin
      prod_s[i] = $signed(ifm) * $signed(kernels[i*WIDTH +: WIDTH]);
    end
  end

  // Datapath next-state: accumulate, address/pixel counters, quantised result capture
  always_comb begin
    rom_addr_d  = rom_addr_q;
    pixel_idx_d = pixel_idx_q;
    ofm_d       = ofm_q;
    for (int i = 0; i < DSP_NO; i++) begin
      acc_d[i] = acc_q[i];
    end
    if ((state_q == S_IDLE) && start) begin
      rom_addr_d  = '0;
      pixel_idx_d = '0;
      for (int i = 0; i < DSP_NO; i++) begin
        acc_d[i] = '0;
      end
    end else if (accept_s) begin
      rom_addr_d = last_beat_s ? '0 : rom_addr_q + AW'(1);
      for (int i = 0; i < DSP_NO; i++) begin
        acc_d[i] = acc_q[i] + ACCW'(prod_s[i]);
      end
    end else if (handshake_s) begin
      pixel_idx_d = pixel_idx_q + PW'(1);
      for (int i = 0; i < DSP_NO; i++) begin
        acc_d[i] = '0;
      end
    end else begin
      rom_addr_d = rom_addr_q;
    end
    if (state_q == S_QUANT) begin
      for (int i = 0; i < DSP_NO; i++) begin
        ofm_d[i*WIDTH +: WIDTH] = quantise(acc_q[i], bias[i*2*WIDTH +: 2*WIDTH]);
      end
    end else begin
      ofm_d = ofm_q;
    end
  end

  // Datapath registers; a reset discards any partial pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_q  <= '0;
      pixel_idx_q <= '0;
      ofm_q       <= '0;
      for (int i = 0; i < DSP_NO; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      rom_addr_q  <= rom_addr_d;
      pixel_idx_q <= pixel_idx_d;
      ofm_q       <= ofm_d;
      for (int i = 0; i < DSP_NO; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pixel_idx = pixel_idx_q;
  assign ofm       = ofm_q;

endmodule

// File: tb/tb_fire_expand_engine.sv
// Directed bench: two engines (RELU=1 and RELU=0) share stimulus; expected values are hand-computed.
module tb_fire_expand_engine;
  localparam int W = 16, D = 4, C = 2, K = 3, WO = 2, F = 14, N = 18;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         ifm_valid = 1'b0;
  logic         ram_ready = 1'b0;
  logic [15:0]  ifm = 16'h0;
  logic [63:0]  kernels = 64'h0;
  logic [127:0] bias = 128'h0;

  logic        ifm_ready_r, ofm_valid_r, busy_r, done_r;
  logic [4:0]  rom_addr_r;
  logic [63:0] ofm_r;
  logic [2:0]  pixel_idx_r;
  logic        ifm_ready_l, ofm_valid_l, busy_l, done_l;
  logic [4:0]  rom_addr_l;
  logic [63:0] ofm_l;
  logic [2:0]  pixel_idx_l;

  int checks = 0;
  int errors = 0;

  fire_expand_engine #(.WIDTH(W), .DSP_NO(D), .CHIN(C), .KERNEL_DIM(K), .WOUT(WO),
                       .FRAC(F), .RELU(1)) u_relu (
    .clk(clk), .rst(rst), .start(start), .ifm(ifm), .ifm_valid(ifm_valid),
    .ifm_ready(ifm_ready_r), .rom_addr(rom_addr_r), .kernels(kernels), .bias(bias),
    .ofm(ofm_r), .ofm_valid(ofm_valid_r), .ram_ready(ram_ready),
    .pixel_idx(pixel_idx_r), .busy(busy_r), .done(done_r));

  fire_expand_engine #(.WIDTH(W), .DSP_NO(D), .CHIN(C), .KERNEL_DIM(K), .WOUT(WO),
                       .FRAC(F), .RELU(0)) u_lin (
    .clk(clk), .rst(rst), .start(start), .ifm(ifm), .ifm_valid(ifm_valid),
    .ifm_ready(ifm_ready_l), .rom_addr(rom_addr_l), .kernels(kernels), .bias(bias),
    .ofm(ofm_l), .ofm_valid(ofm_valid_l), .ram_ready(ram_ready),
    .pixel_idx(pixel_idx_l), .busy(busy_l), .done(done_l));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rep4(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  task automatic reset_values(input string tag);
    chk({tag, "_ofm"}, ofm_r, 64'h0);
    chk({tag, "_ofm_l"}, ofm_l, 64'h0);
    chk({tag, "_ctrl"}, {59'h0, ofm_valid_r, ifm_ready_r, busy_r, done_r, 1'b0}, 64'h0);
    chk({tag, "_addr_idx"}, {56'h0, rom_addr_r, pixel_idx_r}, 64'h0);
  endtask

  // Feed one pixel's N beats from the current negedge; ends in the first OUT cycle.
  task automatic feed(input logic [15:0] px, input bit gaps);
    int cnt = 0;
    int cyc = 0;
    ifm = px;
    while (cnt < N && cyc < 400) begin
      if (ifm_ready_r) chk("rom_addr_seq", {59'h0, rom_addr_r}, 64'(cnt));
      ifm_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (ifm_valid && ifm_ready_r) cnt++;
      @(negedge clk);
      cyc++;
    end
    if (cnt < N) chk("feed_timeout", 64'(cnt), 64'(N));
    ifm_valid = 1'b0;
    chk("quant_cycle_valid", {63'h0, ofm_valid_r}, 64'h0);
    chk("quant_cycle_ready", {63'h0, ifm_ready_r}, 64'h0);
    @(negedge clk);
    chk("ofm_valid_latency", {63'h0, ofm_valid_r}, 64'h1);
  endtask

  task automatic handshake(input logic [2:0] exp_idx);
    ram_ready = 1'b1;
    @(negedge clk);
    ram_ready = 1'b0;
    chk("hs_ofm_valid_drop", {63'h0, ofm_valid_r}, 64'h0);
    chk("hs_pixel_idx", {61'h0, pixel_idx_r}, {61'h0, exp_idx});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    chk("start_ready", {63'h0, ifm_ready_r}, 64'h1);
    chk("start_busy", {63'h0, busy_r}, 64'h1);

    // pixel 0: all positive, 18*2^20 >> 14 = 1152
    kernels = rep4(16'h0400);
    bias    = 128'h0;
    feed(16'h0400, 1'b0);
    chk("p0_ofm_relu", ofm_r, rep4(16'h0480));
    chk("p0_ofm_lin", ofm_l, rep4(16'h0480));
    handshake(3'd1);
    chk("p0_ready_back", {63'h0, ifm_ready_r}, 64'h1);

    // pixel 1: negative weights, output stall of 5 cycles, stray start ignored
    kernels = rep4(16'hFC00);
    feed(16'h0400, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start = (i == 0);
      chk("stall_valid", {63'h0, ofm_valid_r}, 64'h1);
      chk("stall_ofm_relu", ofm_r, 64'h0);
      chk("stall_ofm_lin", ofm_l, rep4(16'hFB80));
      chk("stall_ready", {63'h0, ifm_ready_r}, 64'h0);
      chk("stall_rom_addr", {59'h0, rom_addr_r}, 64'h0);
      @(negedge clk);
    end
    start = 1'b0;
    handshake(3'd2);
    chk("midlayer_start_busy", {63'h0, busy_r}, 64'h1);

    // pixel 2: per-channel weights, bias on ch0, random valid gaps
    kernels = {16'h0200, 16'hFC00, 16'h0800, 16'h0400};
    bias    = {32'd0, 32'd0, 32'd0, 32'd65536};
    feed(16'h0400, 1'b1);
    chk("p2_ofm_relu", ofm_r, {16'h0240, 16'h0000, 16'h0900, 16'h0484});
    chk("p2_ofm_lin", ofm_l, {16'h0240, 16'hFB80, 16'h0900, 16'h0484});
    handshake(3'd3);

    // pixel 3 (last): saturation both directions
    kernels = {16'h8001, 16'h8001, 16'h7FFF, 16'h7FFF};
    bias    = 128'h0;
    feed(16'h7FFF, 1'b0);
    chk("p3_ofm_relu", ofm_r, {16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF});
    chk("p3_ofm_lin", ofm_l, {16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF});
    handshake(3'd4);
    chk("done_pulse", {63'h0, done_r}, 64'h1);
    chk("done_busy_low", {63'h0, busy_r}, 64'h0);
    @(negedge clk);
    chk("done_single", {63'h0, done_r}, 64'h0);
    chk("idle_ready", {63'h0, ifm_ready_r}, 64'h0);
    chk("idle_busy", {63'h0, busy_r}, 64'h0);

    // second layer run
    pulse_start();
    chk("rerun_idx", {61'h0, pixel_idx_r}, 64'h0);
    chk("rerun_busy", {63'h0, busy_r}, 64'h1);
    kernels = rep4(16'h0400);
    feed(16'h0400, 1'b0);
    chk("rerun_ofm", ofm_r, rep4(16'h0480));
    handshake(3'd1);

    // reset after 7 beats of a pixel, then a clean pixel
    ifm_valid = 1'b1;
    repeat (7) @(negedge clk);
    ifm_valid = 1'b0;
    rst = 1'b1;
    #1;
    reset_values("midrst");
    @(negedge clk);
    reset_values("midrst_hold");
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    feed(16'h0400, 1'b0);
    chk("postrst_ofm_relu", ofm_r, rep4(16'h0480));
    chk("postrst_ofm_lin", ofm_l, rep4(16'h0480));
    handshake(3'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fire_expand_engine.md
# fire_expand_engine

Parametrised successor of the fixed fire expand layers: a single conv-expand engine configurable for 1x1 or 3x3 kernels, arbitrary input-channel count, output count and fractional format. It replaces the per-layer free-running clear counter with a start/done FSM and valid/ready handshakes on the input and output sides. It sits between the line-buffer/IFM streamer and the output feature RAM, with an external combinational weight ROM and a bias table.

## Interface
- WIDTH, 16, pixel/weight width (signed fixed point)
- DSP_NO, 128, parallel output channels (one MAC each)
- CHIN, 32, input channels
- KERNEL_DIM, 3, kernel side (1 or 3)
- WOUT, 32, output feature-map side; layer = WOUT*WOUT pixels
- FRAC, 14, right shift from product scale to output scale
- RELU, 1, 1 clamps negative results to 0
- Derived: N = KERNEL_DIM*KERNEL_DIM*CHIN beats/pixel; ACCW = 2*WIDTH + $clog2(N)
- clk  in  1  clock
- rst  in  1  reset: one clock; reset is asynchronous and active-high
- start  in  1  launch layer; honoured only in IDLE
- ifm  in  WIDTH  input pixel beat (signed)
- ifm_valid  in  1  ifm beat valid
- ifm_ready  out  1  engine accepts beat
- rom_addr  out  $clog2(N)  weight ROM address
- kernels  in  WIDTH x DSP_NO  ROM data for rom_addr, same cycle
- bias  in  2*WIDTH x DSP_NO  signed bias, product scale
- ofm  out  WIDTH x DSP_NO  quantised outputs
- ofm_valid  out  1  ofm holds a pixel result
- ram_ready  in  1  output RAM accepts ofm
- pixel_idx  out  $clog2(WOUT*WOUT+1)  pixels completed in this layer
- busy  out  1  high from start accepted until done
- done  out  1  one-cycle pulse at layer end

## Operation
- FSM: IDLE -> ACCUM on start (accumulators cleared, rom_addr=0, pixel_idx=0). ACCUM -> QUANT after N-th accepted beat. QUANT -> OUT. OUT -> ACCUM on ram_ready if pixel_idx+1 < WOUT*WOUT, else -> DONE. DONE -> IDLE unconditionally.
- Beat accepted when ifm_valid && ifm_ready; ifm_ready = (state==ACCUM).
- On accept: acc[i] += ifm * kernels[i] (signed, full ACCW width, no overflow possible); rom_addr increments, wraps to 0 after N-1.
- QUANT: s = acc[i] + sign-extend(bias[i]); q = s >>> FRAC (arithmetic, truncate toward -inf); if RELU and q<0 then 0; saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; register into ofm[i].
- OUT: ofm_valid=1, ofm stable until ram_ready sampled high; on that edge pixel_idx increments, accumulators clear, ofm_valid drops.
- start while not IDLE ignored. ifm_valid outside ACCUM ignored.
- Reset mid-operation: all state cleared, returns to IDLE; partial pixel discarded.

## Timing
- Reset values: ofm all 0, ofm_valid 0, ifm_ready 0, rom_addr 0, pixel_idx 0, busy 0, done 0.
- start at edge t -> ifm_ready=1 and busy=1 from cycle t+1.
- Last beat accepted at edge t -> QUANT in t+1, ofm_valid=1 from t+2 (2-cycle latency).
- ram_ready high in first OUT cycle -> ofm_valid high exactly one cycle; ifm_ready back at next cycle.
- Minimum pixel period N+2 cycles with no stalls.
- done pulses the cycle after the last OUT handshake; busy falls with done; IDLE next cycle.
- ifm_valid gaps stall accumulation only; rom_addr holds.

## Test plan
- DSP_NO=4, CHIN=2, K=3, WOUT=2, FRAC=14: ifm=16'h0400, kernels all 16'h0400, bias 0, 18 beats -> ofm=1152 each, ofm_valid two cycles after last beat.
- Kernels 16'hFC00 same stimulus -> ofm=0 with RELU=1; ofm=16'hFB80 (-1152) with RELU=0; bias 32'd65536 with positive case -> 1156.
- ifm=16'h7FFF, kernels 16'h7FFF -> ofm=16'h7FFF (saturated); negative kernels with RELU=0 -> 16'h8000.
- ram_ready low 5 cycles in OUT -> ofm_valid stays 1, ofm stable, ifm_ready 0, rom_addr frozen; random ifm_valid gaps -> identical results.
- Full layer: 4 pixels -> pixel_idx 0..4, done single pulse, busy falls; start asserted mid-layer ignored; second start reruns layer correctly.
- rst asserted after 7 beats, released, start -> first pixel result 1152 (no residue), all outputs at reset values during rst.
